// File: rtl/seven_seg_count_monitor_if.sv
// Display-side bundle: the active-low segment drive plus the decoded readback
// produced by seven_seg_count_monitor.
interface seven_seg_count_monitor_if #(
  parameter int unsigned ERR_W = 8
) ();
  logic [6:0]       HEX0;
  logic [6:0]       HEX1;
  logic [3:0]       digit_ones;
  logic [3:0]       digit_tens;
  logic [4:0]       value;
  logic             value_valid;
  logic             update;
  logic             seg_error;
  logic             step_error;
  logic             reset_seen;
  logic [ERR_W-1:0] error_count;

  // The display driver owns the segments and observes the readback.
  modport master (
    output HEX0, HEX1,
    input  digit_ones, digit_tens, value, value_valid, update,
           seg_error, step_error, reset_seen, error_count
  );

  modport slave (
    input  HEX0, HEX1,
    output digit_ones, digit_tens, value, value_valid, update,
           seg_error, step_error, reset_seen, error_count
  );
endinterface

// File: rtl/seven_seg_count_monitor.sv
// Readback checker for a two-digit BCD counter display: filters the active-low segment
// drive, decodes it to BCD/binary and flags illegal patterns and illegal count steps.
module seven_seg_count_monitor #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned MAX_COUNT     = 20,
  parameter int unsigned ERR_W         = 8
) (
  input logic                      CLOCK_50,
  input logic                      KEY0,
  seven_seg_count_monitor_if.slave mon
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] StableVal = CntW'(STABLE_CYCLES);
  localparam logic [6:0] MaxVal7 = 7'(MAX_COUNT);
  localparam logic [4:0] MaxVal5 = 5'(MAX_COUNT);

  typedef enum logic [1:0] {StEmpty, StTrack, StFault} state_e;

  // Returns {legal, digit}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  logic [13:0]      sample_q, sample_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             handled_q, handled_d;
  state_e           state_q, state_d;
  logic [3:0]       ones_q, ones_d, tens_q, tens_d;
  logic [4:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;
  logic             seg_err_q, seg_err_d;
  logic             step_err_q, step_err_d;
  logic             rst_seen_q, rst_seen_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [13:0] raw;
  logic        changed, stable, new_run;
  logic [4:0]  dec_hi, dec_lo;
  logic [6:0]  full_val;
  logic [4:0]  new_val;
  logic        legal, step_ok;

  assign raw     = {mon.HEX1, mon.HEX0};
  assign changed = (raw != sample_q);
  assign stable  = (cnt_q == StableVal);
  // A stable run is acted on exactly once, on its first stable cycle.
  assign new_run = stable && !handled_q;

  assign dec_hi   = seg_decode(sample_q[13:7]);
  assign dec_lo   = seg_decode(sample_q[6:0]);
  assign full_val = {3'b0, dec_hi[3:0]} * 7'd10 + {3'b0, dec_lo[3:0]};
  assign new_val  = full_val[4:0];
  assign legal    = dec_hi[4] && dec_lo[4] && (full_val <= MaxVal7);
  assign step_ok  = (new_val == value_q + 5'd1) || ((value_q == MaxVal5) && (new_val == 5'd0));

  // Glitch filter
  always_comb begin
    sample_d  = raw;
    cnt_d     = cnt_q;
    handled_d = handled_q | stable;
    if (changed) begin
      cnt_d     = CntW'(1);
      handled_d = 1'b0;
    end else if (cnt_q != StableVal) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Tracking FSM
  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    value_d    = value_q;
    valid_d    = valid_q;
    seg_err_d  = seg_err_q;
    err_cnt_d  = err_cnt_q;
    update_d   = 1'b0;
    step_err_d = 1'b0;
    rst_seen_d = 1'b0;
    unique case (state_q)
      StEmpty, StFault: begin
        if (new_run) begin
          if (legal) begin
            ones_d    = dec_lo[3:0];
            tens_d    = dec_hi[3:0];
            value_d   = new_val;
            valid_d   = 1'b1;
            update_d  = 1'b1;
            seg_err_d = 1'b0;
            state_d   = StTrack;
          end else begin
            seg_err_d = 1'b1;
            state_d   = StFault;
          end
        end
      end
      StTrack: begin
        if (new_run) begin
          if (!legal) begin
            seg_err_d = 1'b1;
            state_d   = StFault;
          end else if (new_val != value_q) begin
            ones_d   = dec_lo[3:0];
            tens_d   = dec_hi[3:0];
            value_d  = new_val;
            update_d = 1'b1;
            if (!step_ok) begin
              // new_val differs from value_q, so a 00 here always follows a non-00 value
              if (new_val == 5'd0) begin
                rst_seen_d = 1'b1;
              end else begin
                step_err_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
              end
            end
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      sample_q   <= '0;
      cnt_q      <= '0;
      handled_q  <= 1'b0;
      state_q    <= StEmpty;
      ones_q     <= '0;
      tens_q     <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      seg_err_q  <= 1'b0;
      step_err_q <= 1'b0;
      rst_seen_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      sample_q   <= sample_d;
      cnt_q      <= cnt_d;
      handled_q  <= handled_d;
      state_q    <= state_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      seg_err_q  <= seg_err_d;
      step_err_q <= step_err_d;
      rst_seen_q <= rst_seen_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign mon.digit_ones  = ones_q;
  assign mon.digit_tens  = tens_q;
  assign mon.value       = value_q;
  assign mon.value_valid = valid_q;
  assign mon.update      = update_q;
  assign mon.seg_error   = seg_err_q;
  assign mon.step_error  = step_err_q;
  assign mon.reset_seen  = rst_seen_q;
  assign mon.error_count = err_cnt_q;

endmodule

// File: tb/tb_seven_seg_count_monitor.sv
// Scoreboard bench for seven_seg_count_monitor: a per-edge reference model queues the
// expected readback events and a negedge monitor pops and compares them.
module tb_seven_seg_count_monitor;
  localparam int STABLE = 2;
  localparam int MAXC   = 20;
  localparam int ERRW   = 2;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic CLOCK_50 = 1'b0;
  logic KEY0     = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  seven_seg_count_monitor_if #(.ERR_W(ERRW)) bus ();

  seven_seg_count_monitor #(
    .STABLE_CYCLES(STABLE),
    .MAX_COUNT    (MAXC),
    .ERR_W        (ERRW)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .KEY0    (KEY0),
    .mon     (bus)
  );

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct {
    int edge_no;
    bit is_seg;
    int val;
    int tens;
    int ones;
    bit valid;
    bit step;
    bit rst;
    int err;
    bit seg;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_no = 0;

  // Reference model state
  int          run_len = 0;
  logic [13:0] run_pat = '0;
  int          last_val = -1;   // -1: next accepted value is not step-checked
  bit          faulted = 0;
  int          m_val = 0, m_tens = 0, m_ones = 0, m_err = 0;
  bit          m_valid = 0, m_seg = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_no);
    end
  endtask

  function automatic logic [13:0] enc(input int v);
    logic [6:0] t, o;
    t = seg_tab[v / 10];
    o = seg_tab[v % 10];
    return {t, o};
  endfunction

  function automatic int dec_digit(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  task automatic push_event(input bit is_seg, input bit step, input bit rst);
    exp_t e;
    e.edge_no = edge_no + 1;
    e.is_seg  = is_seg;
    e.val     = m_val;
    e.tens    = m_tens;
    e.ones    = m_ones;
    e.valid   = m_valid;
    e.step    = step;
    e.rst     = rst;
    e.err     = m_err;
    e.seg     = m_seg;
    q.push_back(e);
  endtask

  task automatic evaluate(input logic [13:0] pat);
    int t, o, v;
    bit step, rst;
    t = dec_digit(pat[13:7]);
    o = dec_digit(pat[6:0]);
    v = t * 10 + o;
    if (t >= 0 && o >= 0 && v <= MAXC) begin
      if (last_val < 0 || v != last_val) begin
        step = 0;
        rst  = 0;
        if (last_val >= 0 && !(v == last_val + 1 || (last_val == MAXC && v == 0))) begin
          if (v == 0) rst = 1;
          else begin
            step = 1;
            if (m_err < ERRMAX) m_err++;
          end
        end
        m_val = v; m_tens = t; m_ones = o; m_valid = 1; m_seg = 0;
        faulted  = 0;
        last_val = v;
        push_event(0, step, rst);
      end
    end else if (!faulted) begin
      faulted  = 1;
      last_val = -1;
      m_seg    = 1;
      push_event(1, 0, 0);
    end
  endtask

  task automatic model_step(input logic [13:0] pat, input logic key);
    bit bumped;
    if (!key) begin
      // Events the DUT would have registered at this edge are lost to the reset.
      while (q.size() > 0 && q[$].edge_no == edge_no) void'(q.pop_back());
      run_len = 0; last_val = -1; faulted = 0;
      m_val = 0; m_tens = 0; m_ones = 0; m_err = 0; m_valid = 0; m_seg = 0;
    end else begin
      bumped = 0;
      if (run_len == 0 || pat != run_pat) begin
        run_pat = pat; run_len = 1; bumped = 1;
      end else if (run_len < STABLE) begin
        run_len++; bumped = 1;
      end
      if (bumped && run_len == STABLE) evaluate(pat);
    end
  endtask

  task automatic drive(input logic [13:0] pat, input logic key);
    {bus.HEX1, bus.HEX0} = pat;
    KEY0 = key;
    @(posedge CLOCK_50);
    edge_no++;
    model_step(pat, key);
    #1;
  endtask

  task automatic hold(input logic [13:0] pat, input int n);
    repeat (n) drive(pat, 1'b1);
  endtask

  task automatic check_cleared();
    check("rst_value", int'(bus.value), 0);
    check("rst_digits", int'({bus.digit_tens, bus.digit_ones}), 0);
    check("rst_flags", int'({bus.value_valid, bus.update, bus.seg_error, bus.step_error,
                             bus.reset_seen}), 0);
    check("rst_err_count", int'(bus.error_count), 0);
  endtask

  // Monitor: pops one expectation per update pulse or seg_error rise.
  logic seg_prev = 1'b0;
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (bus.update === 1'b1 || (bus.seg_error === 1'b1 && seg_prev !== 1'b1)) begin
      if (q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = q.pop_front();
        check("event_edge", edge_no, e.edge_no);
        check("event_kind_update", int'(bus.update), int'(!e.is_seg));
        check("value", int'(bus.value), e.val);
        check("digit_tens", int'(bus.digit_tens), e.tens);
        check("digit_ones", int'(bus.digit_ones), e.ones);
        check("value_valid", int'(bus.value_valid), int'(e.valid));
        check("step_error", int'(bus.step_error), int'(e.step));
        check("reset_seen", int'(bus.reset_seen), int'(e.rst));
        check("error_count", int'(bus.error_count), e.err);
        check("seg_error", int'(bus.seg_error), int'(e.seg));
      end
    end else if (bus.step_error === 1'b1 || bus.reset_seen === 1'b1) begin
      check("pulse_without_update", 1, 0);
    end
    seg_prev <= bus.seg_error;
  end

  initial begin
    logic [13:0] pat;
    int cur_v, r, n;

    // Reset hold with "07" shown, then release
    repeat (3) begin
      drive(enc(7), 1'b0);
      check_cleared();
    end
    hold(enc(7), 3);

    // Full count with wrap
    for (int v = 0; v <= MAXC; v++) hold(enc(v), 3);
    hold(enc(0), 3);
    check("wrap_err_count", int'(bus.error_count), 0);

    // Glitch rejection
    hold(enc(5), 3);
    drive({seg_tab[0], 7'b1111111}, 1'b1);
    hold(enc(5), 3);
    drive(enc(6), 1'b1);
    hold(enc(5), 3);
    check("glitch_value", int'(bus.value), 5);
    check("glitch_seg_error", int'(bus.seg_error), 0);

    // Illegal step, reset step, out-of-range pattern
    hold(enc(3), 3);
    hold(enc(5), 3);
    hold(enc(0), 3);
    hold(enc(23), 4);
    check("over_max_value_held", int'(bus.value), 0);

    // Fault recovery
    hold(enc(0), 3);
    hold({seg_tab[0], 7'b1111111}, 4);
    hold(enc(9), 4);

    // Saturation, then a single-edge reset mid-sequence
    hold(enc(12), 3);
    hold(enc(3), 3);
    hold(enc(15), 3);
    hold(enc(7), 3);
    hold(enc(18), 3);
    check("err_saturated", int'(bus.error_count), ERRMAX);
    drive(enc(18), 1'b0);
    check_cleared();
    hold(enc(18), 3);
    hold(enc(5), 3);

    // Randomized traffic
    cur_v = 5;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        repeat ($urandom_range(1, 2)) drive(enc(cur_v), 1'b0);
      end else begin
        if (r < 55) begin
          cur_v = (cur_v >= MAXC) ? 0 : cur_v + 1;
          pat = enc(cur_v);
        end else if (r < 80) begin
          cur_v = $urandom_range(0, 25);
          pat = enc(cur_v);
        end else if (r < 88) begin
          cur_v = 0;
          pat = enc(0);
        end else begin
          pat = 14'($urandom);
        end
        n = $urandom_range(1, 4);
        hold(pat, n);
      end
    end

    // Drain
    hold(enc(cur_v), 6);
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
